// File: rtl/fire_scheduler.sv
// rtl/fire_scheduler.sv - per-timestep fire collection and drain sequencer
//
// Purpose: in COLLECT, round-robin arbitrates neuron fire requests into the fire
// FIFO (one tag per cycle, each neuron at most once per step); in DRAIN, dequeues
// tags to the synapse fan-out stage over a valid/ready handshake.
//
// Ports:
//   clk, asyn_reset_n          clock (rising edge), asynchronous active-low reset
//   step_start, update_done    step control (pulse / level)
//   fire_req, fire_ack         per-neuron request level / one-hot combinational ack
//   fifo_enq, fifo_in_tag      FIFO write side (combinational)
//   fifo_deq, fifo_out_tag     FIFO read side; head tag valid while !fifo_empty
//   fifo_full, fifo_empty      FIFO status
//   spike_valid, spike_tag     registered spike output to fan-out
//   spike_ready                fan-out accept
//   step_done                  registered one-cycle end-of-step pulse
//   busy                       combinational, high outside IDLE

module fire_scheduler #(
    parameter int numneurons = 2,
    parameter int tagbits    = 1
) (
    input  logic                  clk,
    input  logic                  asyn_reset_n,
    input  logic                  step_start,
    input  logic                  update_done,
    input  logic [numneurons-1:0] fire_req,
    output logic [numneurons-1:0] fire_ack,
    output logic                  fifo_enq,
    output logic [tagbits-1:0]    fifo_in_tag,
    output logic                  fifo_deq,
    input  logic [tagbits-1:0]    fifo_out_tag,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  spike_valid,
    output logic [tagbits-1:0]    spike_tag,
    input  logic                  spike_ready,
    output logic                  step_done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        st_idle,
        st_collect,
        st_drain,
        st_done
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [tagbits-1:0]      rr_ptr;
    logic [tagbits-1:0]      rr_after_winner;
    logic [numneurons-1:0]   fired;
    logic [numneurons-1:0]   eligible;
    logic                    grant_found;
    logic [tagbits-1:0]      winner;
    logic                    load;
    int                      idx;

    // Requests only count while collecting and only once per step.
    assign eligible = (state == st_collect) ? (fire_req & ~fired) : '0;

    // Rotating priority scan starting at rr_ptr; wraps at numneurons, which
    // need not be a power of two.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        idx         = 0;
        for (int k = 0; k < numneurons; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= numneurons) begin
                idx = idx - numneurons;
            end
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                winner      = tagbits'(idx);
            end
        end
    end

    assign rr_after_winner = (int'(winner) == numneurons - 1) ? '0 : winner + 1'b1;

    assign fifo_enq    = grant_found & ~fifo_full;
    assign fifo_in_tag = fifo_enq ? winner : '0;
    assign fire_ack    = fifo_enq ? (numneurons'(1) << winner) : '0;

    // A new head is loaded whenever the output register is empty or being drained.
    assign load     = (state == st_drain) & ~fifo_empty & (~spike_valid | spike_ready);
    assign fifo_deq = load;
    assign busy     = (state != st_idle);

    always_comb begin
        state_next = state;
        case (state)
            st_idle: begin
                if (step_start) begin
                    state_next = st_collect;
                end
            end
            st_collect: begin
                if (update_done && (eligible == '0) && !fifo_enq) begin
                    state_next = st_drain;
                end
            end
            st_drain: begin
                if (fifo_empty && !spike_valid) begin
                    state_next = st_done;
                end
            end
            st_done: begin
                state_next = st_idle;
            end
            default: begin
                state_next = st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state       <= st_idle;
            rr_ptr      <= '0;
            fired       <= '0;
            spike_valid <= 1'b0;
            spike_tag   <= '0;
            step_done   <= 1'b0;
        end else begin
            state     <= state_next;
            step_done <= (state_next == st_done);

            if (fifo_enq) begin
                rr_ptr <= rr_after_winner;
            end

            if (state == st_done) begin
                fired <= '0;
            end else begin
                fired <= fired | fire_ack;
            end

            if (load) begin
                spike_valid <= 1'b1;
                spike_tag   <= fifo_out_tag;
            end else if (spike_valid && spike_ready) begin
                spike_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fire_scheduler.sv
// tb/tb_fire_scheduler.sv - self-checking bench for fire_scheduler with a FIFO model

module tb_fire_scheduler;

    localparam int nn = 4;
    localparam int tb = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          step_start;
    logic          update_done;
    logic [nn-1:0] fire_req;
    logic [nn-1:0] fire_ack;
    logic          fifo_enq;
    logic [tb-1:0] fifo_in_tag;
    logic          fifo_deq;
    logic [tb-1:0] fifo_out_tag;
    logic          fifo_full;
    logic          fifo_empty;
    logic          spike_valid;
    logic [tb-1:0] spike_tag;
    logic          spike_ready;
    logic          step_done;
    logic          busy;

    fire_scheduler #(.numneurons(nn), .tagbits(tb)) dut (
        .clk          (clk),
        .asyn_reset_n (rst_n),
        .step_start   (step_start),
        .update_done  (update_done),
        .fire_req     (fire_req),
        .fire_ack     (fire_ack),
        .fifo_enq     (fifo_enq),
        .fifo_in_tag  (fifo_in_tag),
        .fifo_deq     (fifo_deq),
        .fifo_out_tag (fifo_out_tag),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .spike_valid  (spike_valid),
        .spike_tag    (spike_tag),
        .spike_ready  (spike_ready),
        .step_done    (step_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rr_model = 0;
    int q[$];
    bit force_full = 1'b0;

    logic          s_enq, s_deq, s_valid, s_done, s_busy;
    logic [tb-1:0] s_tag, s_stag;
    logic [nn-1:0] s_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty   = (q.size() == 0);
        fifo_full    = force_full || (q.size() >= nn);
        fifo_out_tag = (q.size() == 0) ? '0 : tb'(q[0]);
    endtask

    task automatic sample();
        @(negedge clk);
        s_enq   = fifo_enq;
        s_tag   = fifo_in_tag;
        s_ack   = fire_ack;
        s_deq   = fifo_deq;
        s_valid = spike_valid;
        s_stag  = spike_tag;
        s_done  = step_done;
        s_busy  = busy;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (s_enq) q.push_back(int'(s_tag));
        if (s_deq && q.size() > 0) void'(q.pop_front());
        drive_fifo();
    endtask

    // One full timestep. Expected grant order is the set bits of mask visited
    // cyclically starting at the model's round-robin pointer.
    task automatic run_step(input logic [nn-1:0] mask, input int full_cycles,
                            input int stall_cycles, input bit rnd);
        int  order[$];
        int  gi, oi, cyc, exp_t, pos;
        bit  done_c, done_d, exp_g, exp_v, exp_deq;
        for (int k = 0; k < nn; k++) begin
            pos = (rr_model + k) % nn;
            if (mask[pos]) order.push_back(pos);
        end

        step_start  = 1'b1;
        update_done = 1'b1;
        fire_req    = mask;
        sample();
        check("idle_busy", s_busy, 0);
        check("idle_enq", s_enq, 0);
        advance();
        step_start = 1'b0;

        gi = 0; cyc = 0; done_c = 0;
        while (!done_c && cyc < 200) begin
            force_full  = (cyc < full_cycles) ? 1'b1 : (rnd ? ($urandom_range(0, 3) == 0) : 1'b0);
            update_done = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step_start  = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            drive_fifo();
            sample();
            exp_g = !force_full && (gi < order.size());
            check("collect_busy", s_busy, 1);
            check("collect_enq", s_enq, exp_g);
            check("collect_deq", s_deq, 0);
            if (exp_g) begin
                check("grant_tag", s_tag, order[gi]);
                check("grant_ack", s_ack, 32'd1 << order[gi]);
                gi++;
            end else begin
                check("idle_ack", s_ack, 0);
            end
            if (update_done && !exp_g && gi == order.size()) done_c = 1;
            advance();
            fire_req = fire_req & ~s_ack;
            cyc++;
        end
        if (!done_c) check("collect_timeout", 0, 1);
        if (order.size() > 0) rr_model = (order[order.size()-1] + 1) % nn;

        force_full = 1'b0;
        update_done = 1'b0;
        step_start = 1'b0;
        fire_req = rnd ? nn'($urandom) : '0;
        drive_fifo();

        exp_v = 0; exp_t = 0; oi = 0; cyc = 0; done_d = 0;
        while (!done_d && cyc < 200) begin
            spike_ready = (cyc < stall_cycles) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (rnd) begin
                step_start  = ($urandom_range(0, 2) == 0);
                fire_req    = nn'($urandom);
                update_done = 1'($urandom_range(0, 1));
            end
            sample();
            check("drain_busy", s_busy, 1);
            check("drain_enq", s_enq, 0);
            check("drain_ack", s_ack, 0);
            check("drain_done", s_done, 0);
            check("spike_valid", s_valid, exp_v);
            if (exp_v) check("spike_tag_stable", s_stag, exp_t);
            exp_deq = (q.size() > 0) && (!exp_v || spike_ready);
            check("drain_deq", s_deq, exp_deq);
            if (s_valid && spike_ready) begin
                if (oi < order.size()) check("spike_order", s_stag, order[oi]);
                else check("spike_extra", 1, 0);
                oi++;
            end
            if (!exp_v && q.size() == 0) done_d = 1;
            if (exp_deq) begin
                exp_v = 1;
                exp_t = q[0];
            end else if (exp_v && spike_ready) begin
                exp_v = 0;
            end
            advance();
            cyc++;
        end
        if (!done_d) check("drain_timeout", 0, 1);
        check("spike_count", oi, order.size());

        spike_ready = 1'b0;
        step_start  = 1'b0;
        update_done = 1'b0;
        fire_req    = '0;
        sample();
        check("step_done_pulse", s_done, 1);
        check("done_busy", s_busy, 1);
        advance();
        sample();
        check("step_done_low", s_done, 0);
        check("back_idle", s_busy, 0);
        advance();
    endtask

    initial begin
        bit got_valid;
        rst_n       = 1'b0;
        step_start  = 1'b0;
        update_done = 1'b0;
        fire_req    = '0;
        spike_ready = 1'b0;
        drive_fifo();
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", spike_valid, 0);
        check("rst_done", step_done, 0);
        check("rst_enq", fifo_enq, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // update_done and requests in IDLE must not start anything
        update_done = 1'b1;
        fire_req    = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("idle_ignore_busy", s_busy, 0);
            check("idle_ignore_enq", s_enq, 0);
            advance();
        end
        update_done = 1'b0;
        fire_req    = '0;

        run_step(4'b1111, 0, 0, 1'b0);
        run_step(4'b0101, 0, 0, 1'b0);
        run_step(4'b1001, 0, 0, 1'b0);
        run_step(4'b0010, 3, 0, 1'b0);
        run_step(4'b1011, 0, 2, 1'b0);
        run_step(4'b0000, 0, 0, 1'b0);
        for (int s = 0; s < 30; s++) begin
            run_step(nn'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        end

        // asynchronous reset while a spike is held in DRAIN
        step_start  = 1'b1;
        update_done = 1'b1;
        fire_req    = 4'b0001;
        got_valid   = 0;
        for (int i = 0; i < 20 && !got_valid; i++) begin
            sample();
            if (s_valid) begin
                got_valid = 1;
            end else begin
                advance();
                fire_req   = fire_req & ~s_ack;
                step_start = 1'b0;
            end
        end
        if (!got_valid) check("reset_setup_timeout", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", spike_valid, 0);
        check("midrst_done", step_done, 0);
        check("midrst_deq", fifo_deq, 0);
        check("midrst_ack", fire_ack, 0);
        q.delete();
        rr_model    = 0;
        fire_req    = '0;
        step_start  = 1'b0;
        update_done = 1'b0;
        drive_fifo();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_step(4'b1111, 0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
